// File: rtl/register_scoreboard_if.sv
// Operand-fetch / write-back signal bundle for register_scoreboard.
// master: operand fetch + write-back side (drives requests, observes stalls)
// slave : the scoreboard itself
interface register_scoreboard_if #(
  parameter int NUM_REGS = 16,
  parameter int REG_AW   = 4,
  parameter int DATA_W   = 64
);
  logic                     issue_valid;
  logic                     issue_wr;
  logic [REG_AW-1:0]        issue_dst;
  logic                     src1_used;
  logic                     src2_used;
  logic [REG_AW-1:0]        src1;
  logic [REG_AW-1:0]        src2;
  // [REG_AW-1:0] address, [REG_AW+DATA_W-1:REG_AW] value, [REG_AW+DATA_W] is_write
  logic [REG_AW+DATA_W:0]   reg_address_and_Value_with_is_write;

  logic                     issue_accept;
  logic [1:0]               stalling_control_signal;
  logic                     fwd1_valid;
  logic                     fwd2_valid;
  logic [DATA_W-1:0]        fwd1_data;
  logic [DATA_W-1:0]        fwd2_data;
  logic [NUM_REGS-1:0]      pending_mask;
  logic                     underflow_err;

  modport master (
    output issue_valid, issue_wr, issue_dst, src1_used, src2_used, src1, src2,
           reg_address_and_Value_with_is_write,
    input  issue_accept, stalling_control_signal, fwd1_valid, fwd2_valid,
           fwd1_data, fwd2_data, pending_mask, underflow_err
  );

  modport slave (
    input  issue_valid, issue_wr, issue_dst, src1_used, src2_used, src1, src2,
           reg_address_and_Value_with_is_write,
    output issue_accept, stalling_control_signal, fwd1_valid, fwd2_valid,
           fwd1_data, fwd2_data, pending_mask, underflow_err
  );
endinterface

// File: rtl/register_scoreboard.sv
// register_scoreboard: per-register pending-write counters between operand
// fetch and write-back; stalls fetch on RAW hazards and on counter saturation.
// Optional feature macro: SCOREBOARD_FWD_EN builds the write-back bypass,
// letting a source whose last outstanding write is retiring this cycle issue
// without stalling. Without it fwd*_valid/fwd*_data are tied to 0.
module register_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int REG_AW   = 4,
  parameter int DATA_W   = 64,
  parameter int CNT_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  register_scoreboard_if.slave sb
);
  localparam int               BW      = REG_AW + DATA_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]  cnt      [NUM_REGS];
  logic [CNT_W-1:0]  cnt_next [NUM_REGS];

  logic              ret;
  logic [REG_AW-1:0] ret_r;
  logic              busy1, busy2;
  logic              fwd1, fwd2;
  logic              src_haz, dst_sat;
  logic              accept;
  logic              uf_set;

  assign ret   = sb.reg_address_and_Value_with_is_write[BW-1];
  assign ret_r = sb.reg_address_and_Value_with_is_write[REG_AW-1:0];

  // Source hazards, bypass resolution and destination saturation.
  always_comb begin
    busy1 = sb.src1_used && (cnt[sb.src1] != '0);
    busy2 = sb.src2_used && (cnt[sb.src2] != '0);
`ifdef SCOREBOARD_FWD_EN
    // Only the last outstanding write may be bypassed; an older one still
    // in flight would be overwritten later by a younger write.
    fwd1 = rst_n && busy1 && ret && (ret_r == sb.src1) && (cnt[sb.src1] == CNT_ONE);
    fwd2 = rst_n && busy2 && ret && (ret_r == sb.src2) && (cnt[sb.src2] == CNT_ONE);
`else
    fwd1 = 1'b0;
    fwd2 = 1'b0;
`endif
    src_haz = (busy1 && !fwd1) || (busy2 && !fwd2);
    // A same-cycle retire to the destination frees one slot.
    dst_sat = sb.issue_wr && (cnt[sb.issue_dst] == CNT_MAX) &&
              !(ret && (ret_r == sb.issue_dst));
  end

  // Stall code, accept and forwarded data; stalls are quiet during reset.
  always_comb begin
    sb.stalling_control_signal = 2'b00;
    if (rst_n && sb.issue_valid) begin
      sb.stalling_control_signal = {dst_sat, src_haz};
    end
    accept          = sb.issue_valid && (sb.stalling_control_signal == 2'b00);
    sb.issue_accept = accept;
    sb.fwd1_valid   = fwd1;
    sb.fwd2_valid   = fwd2;
    sb.fwd1_data    = '0;
    sb.fwd2_data    = '0;
`ifdef SCOREBOARD_FWD_EN
    if (fwd1) sb.fwd1_data = sb.reg_address_and_Value_with_is_write[REG_AW +: DATA_W];
    if (fwd2) sb.fwd2_data = sb.reg_address_and_Value_with_is_write[REG_AW +: DATA_W];
`endif
  end

  // Next counter values: +1 on accepted write issue, -1 on retire, both cancel.
  always_comb begin
    uf_set = ret && (cnt[ret_r] == '0);
    for (int r = 0; r < NUM_REGS; r++) begin
      logic inc, dec;
      inc = accept && sb.issue_wr && (sb.issue_dst == REG_AW'(r));
      dec = ret && (ret_r == REG_AW'(r)) && (cnt[r] != '0);
      cnt_next[r] = cnt[r];
      if (inc && !dec) begin
        cnt_next[r] = cnt[r] + CNT_ONE;
      end else if (dec && !inc) begin
        cnt_next[r] = cnt[r] - CNT_ONE;
      end
    end
  end

  // State registers; pending_mask mirrors the counters as they are updated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
      sb.pending_mask  <= '0;
      sb.underflow_err <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r]             <= cnt_next[r];
        sb.pending_mask[r] <= (cnt_next[r] != '0);
      end
      sb.underflow_err <= sb.underflow_err | uf_set;
    end
  end
endmodule

// File: tb/tb_register_scoreboard.sv
// Self-checking bench for register_scoreboard: directed scenarios followed by
// random traffic, all compared against a counter-array reference model.
module tb_register_scoreboard;
  localparam int NUM_REGS = 16;
  localparam int REG_AW   = 4;
  localparam int DATA_W   = 64;
  localparam int MAXC     = 3;
`ifdef SCOREBOARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  register_scoreboard_if #(.NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .DATA_W(DATA_W)) sb ();

  register_scoreboard #(.NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .DATA_W(DATA_W), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb)
  );

  int m_cnt [NUM_REGS];
  bit m_err;
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit v, input bit wr, input int dst,
                        input bit u1, input int s1, input bit u2, input int s2,
                        input bit rw, input int rr, input logic [63:0] rv);
    sb.issue_valid = v;
    sb.issue_wr    = wr;
    sb.issue_dst   = REG_AW'(dst);
    sb.src1_used   = u1;
    sb.src1        = REG_AW'(s1);
    sb.src2_used   = u2;
    sb.src2        = REG_AW'(s2);
    sb.reg_address_and_Value_with_is_write = {rw, rv, REG_AW'(rr)};
  endtask

  task automatic idle_in();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 64'd0);
  endtask

  function automatic logic [NUM_REGS-1:0] model_mask();
    logic [NUM_REGS-1:0] m = '0;
    for (int r = 0; r < NUM_REGS; r++) m[r] = (m_cnt[r] > 0);
    return m;
  endfunction

  // Expected combinational outputs from the model and the current stimulus.
  task automatic check_comb(output bit acc);
    bit rw = sb.reg_address_and_Value_with_is_write[REG_AW+DATA_W];
    int rr = int'(sb.reg_address_and_Value_with_is_write[REG_AW-1:0]);
    logic [63:0] rv = sb.reg_address_and_Value_with_is_write[REG_AW +: DATA_W];
    int s1 = int'(sb.src1), s2 = int'(sb.src2), d = int'(sb.issue_dst);
    bit busy1 = sb.src1_used && m_cnt[s1] > 0;
    bit busy2 = sb.src2_used && m_cnt[s2] > 0;
    bit f1 = rst_n && FWD && busy1 && rw && rr == s1 && m_cnt[s1] == 1;
    bit f2 = rst_n && FWD && busy2 && rw && rr == s2 && m_cnt[s2] == 1;
    bit b0 = rst_n && sb.issue_valid && ((busy1 && !f1) || (busy2 && !f2));
    bit b1 = rst_n && sb.issue_valid && sb.issue_wr && m_cnt[d] == MAXC && !(rw && rr == d);
    acc = sb.issue_valid && !b0 && !b1;
    check("stall", 64'(sb.stalling_control_signal), 64'({b1, b0}));
    check("accept", 64'(sb.issue_accept), 64'(acc));
    check("fwd1_valid", 64'(sb.fwd1_valid), 64'(f1));
    check("fwd2_valid", 64'(sb.fwd2_valid), 64'(f2));
    if (f1 || !FWD) check("fwd1_data", sb.fwd1_data, f1 ? rv : 64'd0);
    if (f2 || !FWD) check("fwd2_data", sb.fwd2_data, f2 ? rv : 64'd0);
  endtask

  // One clock: check comb outputs, apply the edge to the model, check state.
  task automatic cycle();
    bit acc;
    bit rw;
    int rr, d, old;
    #2;
    check_comb(acc);
    rw = sb.reg_address_and_Value_with_is_write[REG_AW+DATA_W];
    rr = int'(sb.reg_address_and_Value_with_is_write[REG_AW-1:0]);
    d  = int'(sb.issue_dst);
    @(posedge clk);
    if (rst_n) begin
      old = m_cnt[rr];
      if (acc && sb.issue_wr) m_cnt[d] = m_cnt[d] + 1;
      if (rw) begin
        if (old > 0) m_cnt[rr] = m_cnt[rr] - 1;
        else m_err = 1'b1;
      end
    end
    #1;
    check("pending_mask", 64'(sb.pending_mask), 64'(model_mask()));
    check("underflow_err", 64'(sb.underflow_err), 64'(m_err));
  endtask

  task automatic model_reset();
    for (int r = 0; r < NUM_REGS; r++) m_cnt[r] = 0;
    m_err = 1'b0;
  endtask

  initial begin
    bit acc;
    int rr;
    model_reset();
    idle_in();
    rst_n = 1'b0;
    #12;
    // Reset behaviour: state cleared, accept follows issue_valid.
    check("rst_mask", 64'(sb.pending_mask), 64'd0);
    check("rst_uf", 64'(sb.underflow_err), 64'd0);
    set_in(1, 1, 6, 1, 3, 1, 4, 0, 0, 64'd0);
    #1;
    check_comb(acc);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_in();
    cycle();

    // Idle source read.
    set_in(1, 0, 0, 1, 3, 0, 0, 0, 0, 64'd0); cycle();

    // RAW on r5.
    set_in(1, 1, 5, 0, 0, 0, 0, 0, 0, 64'd0); cycle();
    set_in(1, 0, 0, 1, 5, 0, 0, 0, 0, 64'd0); cycle();
    set_in(1, 0, 0, 1, 5, 0, 0, 1, 5, 64'd42); cycle();
    set_in(1, 0, 0, 1, 5, 0, 0, 0, 0, 64'd0); cycle();

    // Saturation on r7.
    repeat (3) begin set_in(1, 1, 7, 0, 0, 0, 0, 0, 0, 64'd0); cycle(); end
    set_in(1, 1, 7, 0, 0, 0, 0, 0, 0, 64'd0); cycle();
    set_in(1, 1, 7, 0, 0, 0, 0, 1, 7, 64'd9); cycle();
    set_in(1, 1, 7, 0, 0, 0, 0, 0, 0, 64'd0); cycle();
    repeat (3) begin set_in(0, 0, 0, 0, 0, 0, 0, 1, 7, 64'd1); cycle(); end

    // Simultaneous issue and retire on r2 with one outstanding.
    set_in(1, 1, 2, 0, 0, 0, 0, 0, 0, 64'd0); cycle();
    set_in(1, 1, 2, 0, 0, 0, 0, 1, 2, 64'd5); cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 2, 64'd5); cycle();

    // Forwarding on src2 with a different value.
    set_in(1, 1, 11, 0, 0, 0, 0, 0, 0, 64'd0); cycle();
    set_in(1, 0, 0, 1, 1, 1, 11, 1, 11, 64'hDEAD_BEEF_0123_4567); cycle();
    idle_in(); cycle();

    // Underflow on r9, cleared only by reset.
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 9, 64'd3); cycle();
    idle_in(); cycle();
    @(posedge clk); #1;
    rst_n = 1'b0; model_reset();
    #1;
    check("uf_cleared", 64'(sb.underflow_err), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle();

    // Asynchronous reset mid-cycle with r4 at 2.
    set_in(1, 1, 4, 0, 0, 0, 0, 0, 0, 64'd0); cycle();
    set_in(1, 1, 4, 0, 0, 0, 0, 0, 0, 64'd0); cycle();
    idle_in();
    #1;
    rst_n = 1'b0; model_reset();
    #1;
    check("async_rst_mask", 64'(sb.pending_mask), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle();

    // Random traffic over a few registers to provoke hazards.
    for (int i = 0; i < 1500; i++) begin
      rr = int'($urandom_range(0, 3));
      if ($urandom_range(0, 9) != 0) begin
        for (int r = 0; r < 4; r++) if (m_cnt[r] > 0) rr = r;
      end
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             int'($urandom_range(0, 3)),
             $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
             $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
             $urandom_range(0, 2) == 0, rr, {$urandom, $urandom});
      cycle();
      if (i == 900) begin
        idle_in();
        rst_n = 1'b0; model_reset();
        #1;
        check("rand_rst_mask", 64'(sb.pending_mask), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
